// File: rtl/morse_encoder_if.sv
// rtl/morse_encoder_if.sv - character-in / Morse-symbol-out bundle for morse_encoder
interface morse_encoder_if;
   logic [7:0] charIn;
   logic       charValid;
   logic       charReady;
   logic [1:0] symbolOut;
   logic       busy;
   logic       done;
   logic       badChar;

   modport master (
      output charIn, charValid,
      input  charReady, symbolOut, busy, done, badChar
   );

   modport slave (
      input  charIn, charValid,
      output charReady, symbolOut, busy, done, badChar
   );
endinterface

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - ASCII to Morse symbol encoder with character FIFO
// Symbol codes on symbolOut: 00 idle, 01 dot, 10 dash, 11 letter/word space.
module morse_encoder #(
   parameter int FIFO_DEPTH    = 4,
   parameter int SYMBOL_CYCLES = 1
) (
   input logic            clk,
   input logic            reset,
   morse_encoder_if.slave bus
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int HW = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(SYMBOL_CYCLES - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, SYM, GAP} state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic          push, pop;

   state_t        state, state_nxt;
   logic [2:0]    code_len, len_nxt;
   logic [4:0]    code_pat, pat_nxt;
   logic          code_bad, bad_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [HW-1:0] hold, hold_nxt;

   logic [1:0]    sym_q, sym_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          badc_q, badc_d;
   logic [8:0]    head_code;

   // Returns {invalid, len, pattern}; pattern is left-aligned so bit 4 is the first symbol.
   function automatic logic [8:0] lookup(input logic [7:0] c);
      logic [7:0] u;
      logic [3:0] d;
      logic [8:0] r;
      u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
      d = 4'd0;
      r = {1'b1, 3'd0, 5'b00000};
      if (u >= 8'h30 && u <= 8'h39) begin
         d = 4'(u - 8'h30);
         r = {1'b0, 3'd5, (d <= 4'd5) ? (5'b11111 >> d) : ~(5'b11111 >> (d - 4'd5))};
      end else begin
         case (u)
            8'h20: r = {1'b0, 3'd0, 5'b00000};
            "A":   r = {1'b0, 3'd2, 5'b01000};
            "B":   r = {1'b0, 3'd4, 5'b10000};
            "C":   r = {1'b0, 3'd4, 5'b10100};
            "D":   r = {1'b0, 3'd3, 5'b10000};
            "E":   r = {1'b0, 3'd1, 5'b00000};
            "F":   r = {1'b0, 3'd4, 5'b00100};
            "G":   r = {1'b0, 3'd3, 5'b11000};
            "H":   r = {1'b0, 3'd4, 5'b00000};
            "I":   r = {1'b0, 3'd2, 5'b00000};
            "J":   r = {1'b0, 3'd4, 5'b01110};
            "K":   r = {1'b0, 3'd3, 5'b10100};
            "L":   r = {1'b0, 3'd4, 5'b01000};
            "M":   r = {1'b0, 3'd2, 5'b11000};
            "N":   r = {1'b0, 3'd2, 5'b10000};
            "O":   r = {1'b0, 3'd3, 5'b11100};
            "P":   r = {1'b0, 3'd4, 5'b01100};
            "Q":   r = {1'b0, 3'd4, 5'b11010};
            "R":   r = {1'b0, 3'd3, 5'b01000};
            "S":   r = {1'b0, 3'd3, 5'b00000};
            "T":   r = {1'b0, 3'd1, 5'b10000};
            "U":   r = {1'b0, 3'd3, 5'b00100};
            "V":   r = {1'b0, 3'd4, 5'b00010};
            "W":   r = {1'b0, 3'd3, 5'b01100};
            "X":   r = {1'b0, 3'd4, 5'b10010};
            "Y":   r = {1'b0, 3'd4, 5'b10110};
            "Z":   r = {1'b0, 3'd4, 5'b11000};
            default: r = {1'b1, 3'd0, 5'b00000};
         endcase
      end
      return r;
   endfunction

   // Full FIFO never accepts, even when a pop happens in the same cycle.
   assign push          = bus.charValid && (count < DEPTH_C);
   assign bus.charReady = (count < DEPTH_C);
   assign head_code     = lookup(mem[rd_ptr]);
   assign count_nxt     = count + CW'(push) - CW'(pop);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.charIn;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         code_len <= '0;
         code_pat <= '0;
         code_bad <= 1'b0;
         idx      <= '0;
         hold     <= '0;
         sym_q    <= 2'b00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         badc_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         code_len <= len_nxt;
         code_pat <= pat_nxt;
         code_bad <= bad_nxt;
         idx      <= idx_nxt;
         hold     <= hold_nxt;
         sym_q    <= sym_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         badc_q   <= badc_d;
      end
   end

   // Every transition into LOAD pops the FIFO head into the code registers.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      hold_nxt  = hold;
      len_nxt   = code_len;
      pat_nxt   = code_pat;
      bad_nxt   = code_bad;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop       = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            hold_nxt = '0;
            idx_nxt  = '0;
            if (code_bad) begin
               if (count != '0) begin
                  pop       = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (code_len == 3'd0) begin
               state_nxt = GAP;
            end else begin
               state_nxt = SYM;
            end
         end
         SYM: begin
            if (hold == HOLD_LAST) begin
               hold_nxt = '0;
               if (idx == code_len - 3'd1) begin
                  state_nxt = GAP;
               end else begin
                  idx_nxt = idx + 3'd1;
                  pat_nxt = {code_pat[3:0], 1'b0};
               end
            end else begin
               hold_nxt = hold + 1'b1;
            end
         end
         GAP: begin
            if (hold == HOLD_LAST) begin
               hold_nxt = '0;
               if (count != '0) begin
                  pop       = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               hold_nxt = hold + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (pop)
         {bad_nxt, len_nxt, pat_nxt} = head_code;
   end

   // Outputs are computed from the next state so the registered copies line up with it.
   always_comb begin
      case (state_nxt)
         SYM:     sym_d = pat_nxt[4] ? 2'b10 : 2'b01;
         GAP:     sym_d = 2'b11;
         default: sym_d = 2'b00;
      endcase
      busy_d = (count_nxt != '0) || (state_nxt != IDLE);
      done_d = (state == GAP) && (state_nxt == IDLE);
      badc_d = pop && head_code[8];
   end

   assign bus.symbolOut = sym_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.badChar   = badc_q;
endmodule

// File: tb/tb_morse_encoder.sv
// tb/tb_morse_encoder.sv - self-checking bench for morse_encoder (SYMBOL_CYCLES 1 and 3)
module tb_morse_encoder;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   morse_encoder_if b1 ();
   morse_encoder_if b3 ();

   morse_encoder #(.FIFO_DEPTH(4), .SYMBOL_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   morse_encoder #(.FIFO_DEPTH(4), .SYMBOL_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

   int checks = 0;
   int errors = 0;
   int sel = 0;

   logic [1:0] r_sym;
   logic       r_ready, r_busy, r_done, r_bad;
   assign r_sym   = (sel != 0) ? b3.symbolOut : b1.symbolOut;
   assign r_ready = (sel != 0) ? b3.charReady : b1.charReady;
   assign r_busy  = (sel != 0) ? b3.busy      : b1.busy;
   assign r_done  = (sel != 0) ? b3.done      : b1.done;
   assign r_bad   = (sel != 0) ? b3.badChar   : b1.badChar;

   typedef struct {
      logic [1:0] sym;
      bit         bad;
      bit         done;
      bit         busy;
   } cyc_t;

   typedef struct {
      string s;
      int    sel;
      string exp;
      int    stall;
   } vec_t;

   cyc_t  expq[$];
   vec_t  vecs[$];
   string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [7:0] c, input logic v);
      b1.charIn    = c;
      b3.charIn    = c;
      b1.charValid = v && (sel == 0);
      b3.charValid = v && (sel != 0);
   endtask

   function automatic bit code_of(input logic [7:0] c, output string code);
      logic [7:0] u;
      int d;
      u = c;
      code = "";
      if (u >= "a" && u <= "z") u = u - 8'd32;
      if (u >= "A" && u <= "Z") begin
         code = letters[u - 8'h41];
         return 1'b1;
      end
      if (u >= "0" && u <= "9") begin
         d = u - 8'h30;
         for (int k = 0; k < 5; k++) begin
            if (d == 0 || (d <= 5 && k >= d) || (d > 5 && k < d - 5)) code = {code, "-"};
            else code = {code, "."};
         end
         return 1'b1;
      end
      return (u == 8'h20);
   endfunction

   function automatic cyc_t mk(input logic [1:0] sym, input bit bad, input bit done, input bit busy);
      cyc_t c;
      c.sym = sym; c.bad = bad; c.done = done; c.busy = busy;
      return c;
   endfunction

   // Expected per-cycle trace when the source pushes the whole string back-to-back.
   function automatic void build(input string s, input int sc);
      string code;
      bit ok, last_ok;
      last_ok = 1'b0;
      expq.delete();
      expq.push_back(mk(2'b00, 0, 0, 1));
      for (int i = 0; i < s.len(); i++) begin
         ok = code_of(s[i], code);
         expq.push_back(mk(2'b00, !ok, 0, 1));
         if (ok) begin
            for (int k = 0; k < code.len(); k++)
               for (int r = 0; r < sc; r++)
                  expq.push_back(mk((code[k] == "-") ? 2'b10 : 2'b01, 0, 0, 1));
            for (int r = 0; r < sc; r++)
               expq.push_back(mk(2'b11, 0, 0, 1));
         end
         last_ok = ok;
      end
      expq.push_back(mk(2'b00, 0, last_ok, 0));
      expq.push_back(mk(2'b00, 0, 0, 0));
      expq.push_back(mk(2'b00, 0, 0, 0));
   endfunction

   task automatic run(input string s, input int which, input string exp_sym, input int exp_stall);
      int i, k, guard, stall_at;
      bit started;
      sel = which;
      build(s, (which != 0) ? 3 : 1);
      i = 0; k = 0; guard = 0; stall_at = -1; started = 1'b0;
      while (k < expq.size() && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (started) begin
            chk("sym", r_sym, expq[k].sym);
            chk("badChar", r_bad, expq[k].bad);
            chk("done", r_done, expq[k].done);
            chk("busy", r_busy, expq[k].busy);
            if (k < exp_sym.len())
               chk("table_sym", r_sym, exp_sym[k] - 8'h30);
            k++;
         end
         if (i < s.len()) begin
            drive(s[i], 1'b1);
            if (r_ready) begin
               i++;
               started = 1'b1;
            end else if (stall_at < 0) begin
               stall_at = i;
            end
         end else begin
            drive(8'h00, 1'b0);
         end
      end
      if (k < expq.size()) chk("run_timeout", k, expq.size());
      if (exp_stall >= 0) chk("pushes_before_stall", stall_at, exp_stall);
   endtask

   function automatic vec_t mkv(input string s, input int which, input string e, input int st);
      vec_t v;
      v.s = s; v.sel = which; v.exp = e; v.stall = st;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      string pool, rs;
      int n;
      pool = "ABCEKQSTZaeoqz0159 #*%";
      drive(8'h00, 1'b0);

      vecs.push_back(mkv("E",        0, "00130", -1));
      vecs.push_back(mkv("SOS",      0, "00111302223011130", -1));
      vecs.push_back(mkv("a7",       1, "001112223330222222111111111333", -1));
      vecs.push_back(mkv("#T",       0, "000230", -1));
      vecs.push_back(mkv("A B",      0, "00123030211130", -1));
      vecs.push_back(mkv("0",        0, "002222230", -1));
      vecs.push_back(mkv("#",        0, "000", -1));
      vecs.push_back(mkv("0ABCDEFG", 0, "", 5));
      vecs.push_back(mkv("9x 5",     1, "", -1));

      repeat (3) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         sel = w;
         #1;
         chk("rst_sym", r_sym, 0);
         chk("rst_busy", r_busy, 0);
         chk("rst_done", r_done, 0);
         chk("rst_bad", r_bad, 0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      sel = 0; #1; chk("ready_after_rst1", r_ready, 1);
      sel = 1; #1; chk("ready_after_rst3", r_ready, 1);

      foreach (vecs[v]) run(vecs[v].s, vecs[v].sel, vecs[v].exp, vecs[v].stall);

      for (int t = 0; t < 24; t++) begin
         n = $urandom_range(1, 6);
         rs = "";
         for (int j = 0; j < n; j++) begin
            int p;
            p = $urandom_range(0, pool.len() - 1);
            rs = {rs, pool.substr(p, p)};
         end
         run(rs, $urandom_range(0, 1), "", -1);
      end

      // Reset in the middle of '0' (third dash) with more characters still queued.
      sel = 0;
      @(negedge clk); drive("0", 1'b1);
      @(negedge clk); drive("E", 1'b1);
      @(negedge clk); drive("E", 1'b1);
      @(negedge clk); drive(8'h00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_dash", r_sym, 2);
      chk("pre_reset_busy", r_busy, 1);
      #1 reset = 1'b0;
      #1;
      chk("mid_reset_sym", r_sym, 0);
      chk("mid_reset_busy", r_busy, 0);
      chk("mid_reset_ready", r_ready, 1);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_reset_sym", r_sym, 0);
         chk("post_reset_busy", r_busy, 0);
         chk("post_reset_ready", r_ready, 1);
      end
      run("T", 0, "00230", -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
